// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers and a level interrupt
// that the CPU acknowledges by storing to CTRL.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [29:0] CtrlWord   = BASE_ADDR[31:2];
  localparam logic [29:0] PresetWord = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] CountWord  = BASE_ADDR[31:2] + 30'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic sel_ctrl, sel_preset, sel_count;
  logic wr_any, wr_ctrl, wr_preset, cpu_en_wr;
  logic en_eff, auto_reload;
  logic unused_addr_lsb;

  // Byte offset within a word carries no meaning for word registers.
  assign unused_addr_lsb = ^addr[1:0];

  assign sel_ctrl   = (addr[31:2] == CtrlWord);
  assign sel_preset = (addr[31:2] == PresetWord);
  assign sel_count  = (addr[31:2] == CountWord);
  assign wr_any     = |byteen;
  assign wr_ctrl    = wr_any & sel_ctrl;
  assign wr_preset  = wr_any & sel_preset;
  assign cpu_en_wr  = wr_ctrl & byteen[0];

  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign irq         = ctrl_q[3] & pend_q;

  always_comb begin
    rdata = 32'h0;
    if (sel_ctrl) begin
      rdata = {28'h0, ctrl_q};
    end else if (sel_preset) begin
      rdata = preset_q;
    end else if (sel_count) begin
      rdata = count_q;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    state_d  = state_q;

    if (cpu_en_wr) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (byteen[i]) begin
          preset_d[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end

    // Outside IDLE a concurrent CPU disable is honoured on the same edge.
    en_eff = ctrl_d[0];

    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0]) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = en_eff ? StCnt : StIdle;
      end
      StCnt: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else if (count_q == 32'h0) begin
          state_d = StInt;
          pend_d  = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      StInt: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else if (auto_reload) begin
          pend_d  = 1'b0;
          state_d = StLoad;
        end else begin
          if (!cpu_en_wr) begin
            ctrl_d[0] = 1'b0;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acknowledge beats a same-edge expiry.
    if (wr_ctrl) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'h0;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

endmodule
